wishbone_classic_arbiter: RTL and testbench

WISHBONE_CLASSIC_ARBITER -- requirements
Module: wishbone_classic_arbiter

---
 rtl/wishbone_arb_pkg.sv | 12 +
 rtl/wishbone_classic_arbiter_rr_select.sv | 28 ++
 rtl/wishbone_classic_arbiter.sv | 147 ++++++++++++++
 tb/tb_wishbone_classic_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/wishbone_arb_pkg.sv
// Shared types and constants for the Wishbone classic arbiter.
// Holds the arbiter state encoding and the stall-counter width.
package wishbone_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/wishbone_classic_arbiter_rr_select.sv
// Combinational round-robin picker: one-hot grant to the first requester
// strictly after last_i, wrapping from N-1 back to 0.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last_i) + off) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin Wishbone classic arbiter: N controllers share one device,
// grant held for the whole cyc, stalled strobes end in an arbiter error.
module wishbone_classic_arbiter
    import wishbone_arb_pkg::*;
#(
    parameter int NUM_CTRL  = 4,
    parameter int DAT_WIDTH = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_CTRL-1:0]                  ctrl_cyc_i,
    input  logic [NUM_CTRL-1:0]                  ctrl_stb_i,
    input  logic [NUM_CTRL-1:0]                  ctrl_we_i,
    input  logic [NUM_CTRL-1:0][DAT_WIDTH-1:0]   ctrl_dat_i,
    output logic [NUM_CTRL-1:0]                  ctrl_ack_o,
    output logic [NUM_CTRL-1:0]                  ctrl_err_o,
    output logic [NUM_CTRL-1:0]                  ctrl_rty_o,
    output logic [DAT_WIDTH-1:0]                 ctrl_dat_o,
    output logic                                 dev_cyc_o,
    output logic                                 dev_stb_o,
    output logic                                 dev_we_o,
    output logic [DAT_WIDTH-1:0]                 dev_dat_o,
    input  logic                                 dev_ack_i,
    input  logic                                 dev_err_i,
    input  logic                                 dev_rty_i,
    input  logic [DAT_WIDTH-1:0]                 dev_dat_i,
    output logic [NUM_CTRL-1:0]                  grant_o
);

    localparam int IW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [NUM_CTRL-1:0] grant_q, grant_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_CTRL-1:0] sel;
    logic                sel_vld;
    logic [IW-1:0]       sel_idx;

    logic             busy;
    logic             g_cyc;
    logic             g_stb;
    logic             dev_rsp;
    logic             stall;
    logic             tmo;
    logic [CNT_W-1:0] cnt_inc;

    rr_select #(
        .N  (NUM_CTRL),
        .IW (IW)
    ) u_rr (
        .req_i   (ctrl_cyc_i),
        .last_i  (last_q),
        .gnt_o   (sel),
        .valid_o (sel_vld)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    assign busy    = (state_q == BUSY);
    assign g_cyc   = ctrl_cyc_i[gidx_q];
    assign g_stb   = ctrl_stb_i[gidx_q];
    assign dev_rsp = dev_ack_i | dev_err_i | dev_rty_i;
    assign stall   = busy & g_cyc & g_stb & ~dev_rsp;
    assign cnt_inc = cnt_q + 1'b1;
    // Fires on the stalled cycle that brings the count up to TIMEOUT.
    assign tmo     = stall & (cnt_inc >= TMO);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = BUSY;
                    grant_d = sel;
                    gidx_d  = sel_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                    cnt_d   = '0;
                end else if (dev_rsp || tmo) begin
                    cnt_d = '0;
                end else if (stall) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_CTRL - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dev_cyc_o  = 1'b0;
        dev_stb_o  = 1'b0;
        dev_we_o   = 1'b0;
        dev_dat_o  = '0;
        ctrl_ack_o = '0;
        ctrl_err_o = '0;
        ctrl_rty_o = '0;
        if (busy) begin
            dev_cyc_o          = g_cyc & ~tmo;
            dev_stb_o          = g_stb & ~tmo;
            dev_we_o           = ctrl_we_i[gidx_q];
            dev_dat_o          = ctrl_dat_i[gidx_q];
            ctrl_ack_o[gidx_q] = dev_ack_i;
            ctrl_err_o[gidx_q] = dev_err_i | tmo;
            ctrl_rty_o[gidx_q] = dev_rty_i;
        end
    end

    assign ctrl_dat_o = dev_dat_i;
    assign grant_o    = busy ? grant_q : '0;

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Directed bench for the round-robin Wishbone classic arbiter.
module tb_wishbone_classic_arbiter;

    localparam logic [2:0] NO  = 3'b000;
    localparam logic [2:0] ACK = 3'b100;
    localparam logic [2:0] ERR = 3'b010;
    localparam logic [2:0] RTY = 3'b001;

    typedef struct {
        string      nm;
        logic       rst_n;
        logic [3:0] cyc;
        logic [3:0] stb;
        logic [3:0] we;
        logic [2:0] rsp;
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic [3:0] e_err;
        logic [3:0] e_rty;
        logic [2:0] e_dev;
        logic [7:0] e_dat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      cyc = '0;
    logic [3:0]      stb = '0;
    logic [3:0]      we = '0;
    logic [3:0][7:0] cdat = {8'hD8, 8'hC7, 8'hB6, 8'hA5};
    logic [3:0]      c_ack, c_err, c_rty, gnt;
    logic [7:0]      c_dato, d_dato;
    logic            d_cyc, d_stb, d_we;
    logic            d_ack = 1'b0;
    logic            d_err = 1'b0;
    logic            d_rty = 1'b0;
    logic [7:0]      d_dati = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    wishbone_classic_arbiter #(
        .NUM_CTRL  (4),
        .DAT_WIDTH (8),
        .TIMEOUT   (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ctrl_cyc_i (cyc),
        .ctrl_stb_i (stb),
        .ctrl_we_i  (we),
        .ctrl_dat_i (cdat),
        .ctrl_ack_o (c_ack),
        .ctrl_err_o (c_err),
        .ctrl_rty_o (c_rty),
        .ctrl_dat_o (c_dato),
        .dev_cyc_o  (d_cyc),
        .dev_stb_o  (d_stb),
        .dev_we_o   (d_we),
        .dev_dat_o  (d_dato),
        .dev_ack_i  (d_ack),
        .dev_err_i  (d_err),
        .dev_rty_i  (d_rty),
        .dev_dat_i  (d_dati),
        .grant_o    (gnt)
    );

    function automatic vec_t mk(
        input string nm, input logic r,
        input logic [3:0] c, input logic [3:0] s, input logic [3:0] w,
        input logic [2:0] rsp,
        input logic [3:0] g, input logic [3:0] a,
        input logic [3:0] e, input logic [3:0] y,
        input logic [2:0] dev, input logic [7:0] dat);
        vec_t v;
        v.nm = nm; v.rst_n = r; v.cyc = c; v.stb = s; v.we = w;
        v.rsp = rsp; v.e_gnt = g; v.e_ack = a; v.e_err = e;
        v.e_rty = y; v.e_dev = dev; v.e_dat = dat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [34:0] act,
                         input logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] outs();
        return {gnt, c_ack, c_err, c_rty, d_cyc, d_stb, d_we, d_dato, c_dato};
    endfunction

    task automatic step(input vec_t v);
        @(negedge clk);
        rst_n  = v.rst_n;
        cyc    = v.cyc;
        stb    = v.stb;
        we     = v.we;
        {d_ack, d_err, d_rty} = v.rsp;
        d_dati = d_dati + 8'h3B;
        #1;
        check(v.nm, outs(), {v.e_gnt, v.e_ack, v.e_err, v.e_rty,
                             v.e_dev, v.e_dat, d_dati});
    endtask

    initial begin
        // reset, then single request from ctrl0
        tbl.push_back(mk("rst0",   0, 4'h0, 4'h0, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rst1",   0, 4'h1, 4'h1, 4'h1, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("s_idle", 1, 4'h1, 4'h1, 4'h1, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("s_req",  1, 4'h1, 4'h1, 4'h1, NO,  1, 0, 0, 0, 3'b111, 8'hA5));
        tbl.push_back(mk("s_ack",  1, 4'h1, 4'h1, 4'h1, ACK, 1, 1, 0, 0, 3'b111, 8'hA5));
        tbl.push_back(mk("s_drop", 1, 4'h0, 4'h0, 4'h0, NO,  1, 0, 0, 0, 3'b000, 8'hA5));
        tbl.push_back(mk("s_end",  1, 4'h0, 4'h0, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        // round robin across all four
        tbl.push_back(mk("rr_rst", 0, 4'h0, 4'h0, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_i0",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_g0",  1, 4'hF, 4'hF, 4'h0, ACK, 1, 1, 0, 0, 3'b110, 8'hA5));
        tbl.push_back(mk("rr_d0",  1, 4'hE, 4'hE, 4'h0, NO,  1, 0, 0, 0, 3'b000, 8'hA5));
        tbl.push_back(mk("rr_i1",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_g1",  1, 4'hF, 4'hF, 4'h0, ACK, 2, 2, 0, 0, 3'b110, 8'hB6));
        tbl.push_back(mk("rr_d1",  1, 4'hD, 4'hD, 4'h0, NO,  2, 0, 0, 0, 3'b000, 8'hB6));
        tbl.push_back(mk("rr_i2",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_g2",  1, 4'hF, 4'hF, 4'h0, ERR, 4, 0, 4, 0, 3'b110, 8'hC7));
        tbl.push_back(mk("rr_d2",  1, 4'hB, 4'hB, 4'h0, NO,  4, 0, 0, 0, 3'b000, 8'hC7));
        tbl.push_back(mk("rr_i3",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_g3",  1, 4'hF, 4'hF, 4'h0, RTY, 8, 0, 0, 8, 3'b110, 8'hD8));
        tbl.push_back(mk("rr_d3",  1, 4'h7, 4'h7, 4'h0, NO,  8, 0, 0, 0, 3'b000, 8'hD8));
        tbl.push_back(mk("rr_i4",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        tbl.push_back(mk("rr_g4",  1, 4'hF, 4'hF, 4'h0, ACK, 1, 1, 0, 0, 3'b110, 8'hA5));
        tbl.push_back(mk("rr_d4",  1, 4'h0, 4'h0, 4'h0, NO,  1, 0, 0, 0, 3'b000, 8'hA5));
        tbl.push_back(mk("rr_end", 1, 4'h0, 4'h0, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));

        foreach (tbl[i]) step(tbl[i]);

        // no preemption: ctrl2 holds the bus through three transfers
        step(mk("np_i",   1, 4'h4, 4'h4, 4'h4, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        step(mk("np_t1",  1, 4'h6, 4'h4, 4'h4, ACK, 4, 4, 0, 0, 3'b111, 8'hC7));
        step(mk("np_t2",  1, 4'h6, 4'h4, 4'h4, ACK, 4, 4, 0, 0, 3'b111, 8'hC7));
        step(mk("np_t3",  1, 4'h6, 4'h4, 4'h4, ACK, 4, 4, 0, 0, 3'b111, 8'hC7));
        step(mk("np_d",   1, 4'h2, 4'h0, 4'h0, NO,  4, 0, 0, 0, 3'b000, 8'hC7));
        step(mk("np_i1",  1, 4'h2, 4'h2, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        step(mk("np_g1",  1, 4'h2, 4'h2, 4'h0, ACK, 2, 2, 0, 0, 3'b110, 8'hB6));
        step(mk("np_end", 1, 4'h0, 4'h0, 4'h0, NO,  2, 0, 0, 0, 3'b000, 8'hB6));

        // timeout after four stalled cycles, then a response tie
        step(mk("to_i",   1, 4'h1, 4'h1, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        step(mk("to_s1",  1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("to_s2",  1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("to_s3",  1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("to_s4",  1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 1, 0, 3'b000, 8'hA5));
        step(mk("to_hold",1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("tie_s2", 1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("tie_s3", 1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));
        step(mk("tie_s4", 1, 4'h1, 4'h1, 4'h0, ACK, 1, 1, 0, 0, 3'b110, 8'hA5));
        step(mk("tie_nx", 1, 4'h1, 4'h1, 4'h0, NO,  1, 0, 0, 0, 3'b110, 8'hA5));

        // asynchronous reset in the middle of a busy cycle
        #2;
        d_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), {4'h0, 12'h000, 3'b000, 8'h00, d_dati});
        step(mk("ra_hold", 0, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        step(mk("ra_rel",  1, 4'hF, 4'hF, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));
        step(mk("ra_g0",   1, 4'hF, 4'hF, 4'h0, ACK, 1, 1, 0, 0, 3'b110, 8'hA5));
        step(mk("ra_d0",   1, 4'h0, 4'h0, 4'h0, NO,  1, 0, 0, 0, 3'b000, 8'hA5));
        step(mk("ra_end",  1, 4'h0, 4'h0, 4'h0, NO,  0, 0, 0, 0, 3'b000, 8'h00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
